// File: rtl/program_loader_if.sv
// ============================================================================
// program_loader_if : byte-stream and program-memory write bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface program_loader_if #(
  parameter int ADD_WIDTH = 7
);
  logic                 load_start;
  logic [7:0]           byte_in;
  logic                 byte_valid;
  logic                 byte_ready;
  logic                 pm_wr_en;
  logic [ADD_WIDTH-1:0] pm_addr;
  logic [7:0]           pm_wdata;
  logic                 cpu_rst;
  logic                 load_done;
  logic                 load_err;

  modport master (
    output load_start, byte_in, byte_valid,
    input  byte_ready, pm_wr_en, pm_addr, pm_wdata, cpu_rst, load_done, load_err
  );

  modport slave (
    input  load_start, byte_in, byte_valid,
    output byte_ready, pm_wr_en, pm_addr, pm_wdata, cpu_rst, load_done, load_err
  );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// program_loader : length-prefixed byte-stream loader for CPU program memory
// Optional XOR checksum stage enabled by defining LOADER_CHECKSUM_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module program_loader #(
  parameter int ADD_WIDTH = 7
) (
  input  wire logic        clk,
  input  wire logic        rst,
  program_loader_if.slave  bus
);

  localparam int MAX_INSTR = (1 << ADD_WIDTH) / 4;
  localparam int CNT_W     = ADD_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_LOAD  = 3'd2,
    S_CHK   = 3'd3,
    S_DRAIN = 3'd4,
    S_RUN   = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t               state;
  logic                 byte_ready;
  logic                 pm_wr_en;
  logic [ADD_WIDTH-1:0] pm_addr;
  logic [7:0]           pm_wdata;
  logic                 cpu_rst;
  logic                 load_done;
  logic                 load_err;
  logic [ADD_WIDTH-1:0] addr;
  logic [CNT_W-1:0]     remaining;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  logic accept;
  logic len_bad;
  logic run_hold;

  assign accept   = bus.byte_valid && byte_ready;
  assign len_bad  = (bus.byte_in == 8'd0) || (32'(bus.byte_in) > 32'(MAX_INSTR));
  assign run_hold = (state == S_RUN) && !bus.load_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      pm_wr_en   <= 1'b0;
      pm_addr    <= '0;
      pm_wdata   <= '0;
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      addr       <= '0;
      remaining  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      pm_wr_en  <= 1'b0;
      // Release lags entry into RUN by one edge so the final write commits first.
      cpu_rst   <= !run_hold;
      load_done <= run_hold;

      case (state)
        S_IDLE, S_RUN, S_ERROR: begin
          if (bus.load_start) begin
            state      <= S_LEN;
            byte_ready <= 1'b1;
            load_err   <= 1'b0;
            addr       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end

        S_LEN: begin
          if (accept) begin
            if (len_bad) begin
              state      <= S_ERROR;
              byte_ready <= 1'b0;
              load_err   <= 1'b1;
            end else begin
              state     <= S_LOAD;
              remaining <= CNT_W'({bus.byte_in, 2'b00});
`ifdef LOADER_CHECKSUM_EN
              csum      <= bus.byte_in;
`endif
            end
          end
        end

        S_LOAD: begin
          if (accept) begin
            pm_wr_en  <= 1'b1;
            pm_addr   <= addr;
            pm_wdata  <= bus.byte_in;
            addr      <= addr + ADD_WIDTH'(1);
            remaining <= remaining - CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
            csum      <= csum ^ bus.byte_in;
            if (remaining == CNT_W'(1)) begin
              state <= S_CHK;
            end
`else
            if (remaining == CNT_W'(1)) begin
              state      <= S_DRAIN;
              byte_ready <= 1'b0;
            end
`endif
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (bus.byte_in == csum) begin
              state <= S_DRAIN;
            end else begin
              state    <= S_ERROR;
              load_err <= 1'b1;
            end
          end
        end
`endif

        S_DRAIN: begin
          state <= S_RUN;
        end

        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.pm_wr_en   = pm_wr_en;
  assign bus.pm_addr    = pm_addr;
  assign bus.pm_wdata   = pm_wdata;
  assign bus.cpu_rst    = cpu_rst;
  assign bus.load_done  = load_done;
  assign bus.load_err   = load_err;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// tb_program_loader : table-driven and randomized bench for program_loader
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

  localparam int ADD_WIDTH = 7;
  localparam int MAX_INSTR = (1 << ADD_WIDTH) / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  program_loader_if #(.ADD_WIDTH(ADD_WIDTH)) bus();
  program_loader #(.ADD_WIDTH(ADD_WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [ADD_WIDTH-1:0] addr;
    logic [7:0]           data;
  } wr_t;

  typedef struct {
    logic [7:0] len;
    int         gap_mode;
    bit         exp_err;
  } vec_t;

  wr_t        exp_q[$];
  logic [7:0] payload[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every write must match the next expected (address, data) in stream order.
  always @(negedge clk) begin : monitor
    wr_t w;
    if (bus.pm_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", 32'(bus.pm_addr), 32'(w.addr));
        check("wr_data", 32'(bus.pm_wdata), 32'(w.data));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({tag, "_pm_wr_en"},   32'(bus.pm_wr_en),   32'd0);
    check({tag, "_pm_addr"},    32'(bus.pm_addr),    32'd0);
    check({tag, "_pm_wdata"},   32'(bus.pm_wdata),   32'd0);
    check({tag, "_cpu_rst"},    32'(bus.cpu_rst),    32'd1);
    check({tag, "_load_done"},  32'(bus.load_done),  32'd0);
    check({tag, "_load_err"},   32'(bus.load_err),   32'd0);
  endtask

  // Called and returns at a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap_mode, input bit is_data,
                           input int k, output bit ok);
    int  gaps;
    logic r;
    gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int i = 0; i < gaps; i++) begin
      bus.byte_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    ok = 1'b0;
    for (int w = 0; w < 100; w++) begin
      r = bus.byte_ready;
      @(posedge clk);
      @(negedge clk);
      if (r === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    bus.byte_valid = 1'b0;
    if (!ok) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else if (is_data) begin
      check("wr_latency_en",   32'(bus.pm_wr_en), 32'd1);
      check("wr_latency_addr", 32'(bus.pm_addr),  32'(k));
    end
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.load_start = 1'b0;
    check("len_byte_ready", 32'(bus.byte_ready), 32'd1);
    check("len_cpu_rst",    32'(bus.cpu_rst),    32'd1);
    check("len_load_done",  32'(bus.load_done),  32'd0);
    check("len_load_err",   32'(bus.load_err),   32'd0);
  endtask

  // Last stream byte accepted at edge X; release is expected after edge X+2.
  task automatic check_release();
    check("rel_x1_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("rel_x1_ready",   32'(bus.byte_ready), 32'd0);
    @(negedge clk);
    check("rel_x2_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("rel_x2_done",    32'(bus.load_done), 32'd0);
    @(negedge clk);
    check("rel_x3_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    check("rel_x3_done",    32'(bus.load_done), 32'd1);
    check("rel_x3_err",     32'(bus.load_err), 32'd0);
    check("rel_x3_ready",   32'(bus.byte_ready), 32'd0);
  endtask

  task automatic run_load(input logic [7:0] len, input int gap_mode, input bit exp_err,
                          input bit use_payload, input bit bad_csum);
    logic [7:0] cs;
    logic [7:0] b;
    bit ok;
    pulse_start();
    cs = len;
    send_byte(len, gap_mode, 1'b0, 0, ok);
    if (exp_err) begin
      check("badlen_load_err", 32'(bus.load_err),   32'd1);
      check("badlen_cpu_rst",  32'(bus.cpu_rst),    32'd1);
      check("badlen_ready",    32'(bus.byte_ready), 32'd0);
      check("badlen_wr_en",    32'(bus.pm_wr_en),   32'd0);
      return;
    end
    for (int k = 0; k < 4 * int'(len); k++) begin
      b  = use_payload ? payload[k] : 8'($urandom);
      cs = cs ^ b;
      exp_q.push_back('{addr: ADD_WIDTH'(k), data: b});
      send_byte(b, gap_mode, 1'b1, k, ok);
      if (!ok) return;
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (cs ^ 8'h5A) : cs, gap_mode, 1'b0, 0, ok);
    check("csum_not_written", 32'(bus.pm_wr_en), 32'd0);
    if (bad_csum) begin
      check("csum_err_load_err", 32'(bus.load_err), 32'd1);
      check("csum_err_cpu_rst",  32'(bus.cpu_rst),  32'd1);
      @(negedge clk);
      check("csum_err_hold_rst", 32'(bus.cpu_rst),  32'd1);
      return;
    end
`else
    if (bad_csum) return;
`endif
    check_release();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t       vecs[8];
    logic [7:0] l;
    bit         ok;

    vecs[0] = '{len: 8'd1,   gap_mode: 0, exp_err: 1'b0};
    vecs[1] = '{len: 8'd0,   gap_mode: 0, exp_err: 1'b1};
    vecs[2] = '{len: 8'h21,  gap_mode: 0, exp_err: 1'b1};
    vecs[3] = '{len: 8'd2,   gap_mode: 1, exp_err: 1'b0};
    vecs[4] = '{len: 8'd32,  gap_mode: 2, exp_err: 1'b0};
    vecs[5] = '{len: 8'hFF,  gap_mode: 0, exp_err: 1'b1};
    vecs[6] = '{len: 8'd7,   gap_mode: 2, exp_err: 1'b0};
    vecs[7] = '{len: 8'd1,   gap_mode: 1, exp_err: 1'b0};

    bus.load_start = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h5A;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Bytes offered in IDLE must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready",   32'(bus.byte_ready), 32'd0);
      check("idle_cpu_rst", 32'(bus.cpu_rst),    32'd1);
    end
    bus.byte_valid = 1'b0;

    payload = '{8'h93, 8'h00, 8'h50, 8'h00};
    run_load(8'd1, 0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_load(vecs[i].len, vecs[i].gap_mode, vecs[i].exp_err, 1'b0, 1'b0);
    end

`ifdef LOADER_CHECKSUM_EN
    run_load(8'd1, 0, 1'b0, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 6; i++) begin
      l = 8'($urandom_range(0, 40));
      run_load(l, 2, (l == 8'd0) || (int'(l) > MAX_INSTR), 1'b0, 1'b0);
    end

    // Reset after three of four data bytes abandons the load.
    pulse_start();
    send_byte(8'd1, 0, 1'b0, 0, ok);
    for (int k = 0; k < 3; k++) begin
      l = 8'($urandom);
      exp_q.push_back('{addr: ADD_WIDTH'(k), data: l});
      send_byte(l, 0, 1'b1, k, ok);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("midrst");
    rst = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_ready",   32'(bus.byte_ready), 32'd0);
      check("midrst_cpu_rst", 32'(bus.cpu_rst),    32'd1);
    end
    bus.byte_valid = 1'b0;
    @(negedge clk);

    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
